// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 registered selector.
// Mode encoding and channel-count ceiling.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

  localparam int MUX_MAX_N = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: req[N], ptr -> gnt_valid, gnt_idx.
// Scan starts at ptr and wraps; lowest index in rotated order wins.
module rr_arbiter #(
  parameter  int N     = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [N-1:0]     rot;
  logic [SEL_W-1:0] enc;
  logic [SEL_W:0]   sum;

  // rot[0] is channel ptr, rot[1] is ptr+1, ...
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    enc       = '0;
    gnt_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        enc       = SEL_W'(i);
        gnt_valid = 1'b1;
      end
    end
  end

  // Un-rotate: (enc + ptr) mod N
  assign sum = {1'b0, enc} + {1'b0, ptr};
  assign gnt_idx = (sum >= (SEL_W+1)'(N))
                 ? SEL_W'(sum - (SEL_W+1)'(N))
                 : sum[SEL_W-1:0];

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 selector, fixed or round-robin grant, one output register.
// Ports: data_i/valid_i/ready_o in, out_data_o/out_sel_o/out_valid_o/out_ready_i out.
module mux_nto1_rr #(
  parameter  int WIDTH = 32,
  parameter  int N     = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [N-1:0]       valid_i,
  output logic [N-1:0]       ready_o,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_sel_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  import mux_pkg::*;

  mux_mode_e        mode;
  logic             can_accept;
  logic             accept;
  logic             fix_ok;
  logic             rr_gv;
  logic [SEL_W-1:0] rr_idx;
  logic             gv;
  logic [SEL_W-1:0] g;
  logic [WIDTH-1:0] gdata;
  logic [SEL_W-1:0] ptr;

  assign mode       = mux_mode_e'(mode_i);
  assign can_accept = ~out_valid_o | out_ready_i;
  assign accept     = gv & can_accept;

  rr_arbiter #(.N(N)) u_arb (
    .req       (valid_i),
    .ptr       (ptr),
    .gnt_valid (rr_gv),
    .gnt_idx   (rr_idx)
  );

  // Out-of-range sel_i matches no k, so it never grants.
  always_comb begin
    fix_ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k) && valid_i[k]) fix_ok = 1'b1;
    end
  end

  always_comb begin
    gv = 1'b0;
    g  = '0;
    unique case (1'b1)
      (mode == MUX_FIXED): begin
        gv = fix_ok;
        g  = sel_i;
      end
      (mode == MUX_RR): begin
        gv = rr_gv;
        g  = rr_idx;
      end
      default: ;
    endcase
  end

  always_comb begin
    gdata   = '0;
    ready_o = '0;
    for (int k = 0; k < N; k++) begin
      if (g == SEL_W'(k)) gdata = data_i[k*WIDTH +: WIDTH];
      ready_o[k] = rst_ni & accept & (g == SEL_W'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_data_o  <= '0;
      out_sel_o   <= '0;
      out_valid_o <= 1'b0;
      ptr         <= '0;
    end else begin
      if (accept) begin
        out_data_o  <= gdata;
        out_sel_o   <= g;
        out_valid_o <= 1'b1;
        if (mode == MUX_RR)
          ptr <= (g == SEL_W'(N - 1)) ? '0 : g + SEL_W'(1);
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr (N=16 main, N=12 for out-of-range sel).
// Reference model computes grants from the scan rules with plain arithmetic.
module tb_mux_nto1_rr;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int SW  = 4;
  localparam int N12 = 12;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N*W-1:0] data;
  logic [N-1:0]   valid;
  logic [N-1:0]   ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   od;
  logic [SW-1:0]  os;
  logic           ov;
  logic           ordy;

  logic [N12-1:0] r12;
  logic [W-1:0]   od12;
  logic [3:0]     os12;
  logic           ov12;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } exp_t;

  exp_t q[$];
  int   mptr = 0;
  bit   mv = 1'b0;
  int   seq[3] = '{2, 5, 15};

  always #5 clk = ~clk;

  mux_nto1_rr #(.WIDTH(W), .N(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .mode_i      (mode),
    .sel_i       (sel),
    .out_data_o  (od),
    .out_sel_o   (os),
    .out_valid_o (ov),
    .out_ready_i (ordy)
  );

  mux_nto1_rr #(.WIDTH(W), .N(N12)) dut12 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .data_i      (data[N12*W-1:0]),
    .valid_i     (valid[N12-1:0]),
    .ready_o     (r12),
    .mode_i      (mode),
    .sel_i       (sel),
    .out_data_o  (od12),
    .out_sel_o   (os12),
    .out_valid_o (ov12),
    .out_ready_i (ordy)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic fill_inc();
    for (int k = 0; k < N; k++) data[k*W +: W] = 32'h100 + k;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) data[k*W +: W] = $urandom;
  endtask

  function automatic int ref_grant();
    if (mode == 1'b0) begin
      if (int'(sel) < N && valid[sel]) return int'(sel);
      return -1;
    end
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (mptr + i) % N;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference model: predicts ready_o and the word captured at the next edge.
  always @(negedge clk) begin
    if (!rst_ni) begin
      mv   = 1'b0;
      mptr = 0;
      q.delete();
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_valid", 64'(ov), 64'd0);
      chk("rst_data", 64'(od), 64'd0);
      chk("rst_sel", 64'(os), 64'd0);
    end else begin
      int g;
      bit can;
      g   = ref_grant();
      can = !mv || ordy;
      chk("ready", 64'(ready), (can && g >= 0) ? (64'd1 << g) : 64'd0);
      chk("out_valid", 64'(ov), 64'(mv));
      if (can && g >= 0) begin
        q.push_back('{d: data[g*W +: W], s: g});
        mv = 1'b1;
        if (mode) mptr = (g + 1) % N;
      end else if (ordy) begin
        mv = 1'b0;
      end
    end
  end

  // Monitor: compares the presented word with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_ni && ov) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'(ov), 64'd0);
      end else begin
        chk("out_data", 64'(od), 64'(q[0].d));
        chk("out_sel", 64'(os), 64'(q[0].s));
        if (ordy) void'(q.pop_front());
      end
    end
  end

  initial begin
    fill_inc();
    valid = '1;
    mode  = 1'b1;
    sel   = '0;
    ordy  = 1'b1;
    cyc(3);

    rst_ni = 1'b1;
    @(negedge clk);
    chk("first_rr_grant", 64'(ready), 64'h0001);
    cyc(1);

    mode = 1'b0;
    sel  = 4'd9;
    @(negedge clk);
    chk("fixed_ready", 64'(ready), 64'h0200);
    cyc(1);
    @(negedge clk);
    chk("fixed_data", 64'(od), 64'h109);
    chk("fixed_sel", 64'(os), 64'd9);

    cyc(1);
    sel = 4'd13;
    @(negedge clk);
    chk("oor_ready12", 64'(r12), 64'd0);
    cyc(1);
    @(negedge clk);
    chk("oor_valid12", 64'(ov12), 64'd0);

    cyc(1);
    mode  = 1'b1;
    valid = 16'h8024;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_seq", 64'(ready), 64'd1 << seq[i % 3]);
      cyc(1);
    end

    ordy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(ready), 64'd0);
      chk("bp_sel", 64'(os), 64'd15);
      chk("bp_data", 64'(od), 64'h10f);
      cyc(1);
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_next", 64'(ready), 64'h0004);
    cyc(1);

    valid = 16'h0008;
    @(negedge clk);
    chk("ms_rr3", 64'(ready), 64'h0008);
    cyc(1);
    mode  = 1'b0;
    sel   = 4'd7;
    valid = '1;
    @(negedge clk);
    chk("ms_fix7", 64'(ready), 64'h0080);
    cyc(1);
    mode = 1'b1;
    @(negedge clk);
    chk("ms_rr4", 64'(ready), 64'h0010);
    cyc(1);

    repeat (400) begin
      valid = N'($urandom);
      if ($urandom_range(0, 4) == 0) valid = '0;
      mode = 1'($urandom_range(0, 1));
      sel  = SW'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      fill_rand();
      cyc(1);
    end

    fill_inc();
    valid = '1;
    mode  = 1'b1;
    ordy  = 1'b0;
    cyc(2);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(ov), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    cyc(2);
    rst_ni = 1'b1;
    ordy   = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(ready), 64'h0001);
    cyc(1);

    valid = '0;
    cyc(3);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
